// File: rtl/cp0_exc_if.sv
// Pipeline-to-CP0 bus for the MEM-stage exception controller.
// master: pipeline side, drives the instruction/CP0-access fields and
//         receives redirect, read data and the eret return address.
// slave:  cp0_exc_unit side.
// Handshake: there is no ready. valid qualifies the MEM slot only; req is
// asserted in the same cycle as the qualifying inputs and means "this
// instruction does not commit; flush upstream and fetch handler_pc next".
interface cp0_exc_if;
  logic        valid;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exccode;
  logic [5:0]  hwint;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        eret;
  logic [31:0] dout;
  logic        req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  modport master (
    output valid, pc, bd, exccode, hwint, we, addr, din, eret,
    input  dout, req, handler_pc, epc_out
  );

  modport slave (
    input  valid, pc, bd, exccode, hwint, we, addr, din, eret,
    output dout, req, handler_pc, epc_out
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 and exception controller at the MEM end of the pipeline.
// Decides interrupt/exception entry, keeps SR/Cause/EPC, serves mfc0 reads
// and provides the eret return address.
// Ports:
//   clk       - clock, all state changes on rising edge
//   reset     - synchronous, active-high
//   bus       - cp0_exc_if.slave (valid, pc, bd, exccode, hwint, we, addr,
//               din, eret in; dout, req, handler_pc, epc_out out)
//   state_dbg - 1 while in HANDLER (SR.EXL set)
module cp0_exc_unit #(
  parameter logic [31:0] PRID       = 32'h2020_0707,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic       clk,
  input  logic       reset,
  cp0_exc_if.slave   bus,
  output logic       state_dbg
);

  // The FSM state register is SR.EXL itself.
  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [5:0]  im_q;
  logic        ie_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q;
  logic [31:0] epc_q;

  logic        exl;
  logic        int_req, exc_req, req;
  logic        sr_wr, epc_wr;
  logic [31:0] epc_calc;
  logic [31:0] din_word;

  assign exl      = (state_q == HANDLER);
  assign int_req  = bus.valid & ie_q & ~exl & (|(bus.hwint & im_q));
  assign exc_req  = bus.valid & ~exl & (bus.exccode != 5'd0);
  assign req      = int_req | exc_req;

  // A taking instruction does not commit, so its mtc0 is dropped.
  assign sr_wr    = bus.we & ~req & (bus.addr == 5'd12);
  assign epc_wr   = bus.we & ~req & (bus.addr == 5'd14);
  assign din_word = {bus.din[31:2], 2'b00};
  assign epc_calc = bus.bd ? ((bus.pc - 32'd4) & 32'hFFFF_FFFC)
                           : {bus.pc[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    if (req)
      state_d = HANDLER;
    else if (sr_wr)
      // An explicit SR write defines EXL outright, even alongside eret.
      state_d = bus.din[1] ? HANDLER : NORMAL;
    else if (bus.eret)
      state_d = NORMAL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NORMAL;
      im_q        <= 6'd0;
      ie_q        <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cause_ip_q <= bus.hwint;
      if (req) begin
        cause_bd_q  <= bus.bd;
        cause_exc_q <= int_req ? 5'd0 : bus.exccode;
        epc_q       <= epc_calc;
      end else begin
        if (sr_wr) begin
          im_q <= bus.din[15:10];
          ie_q <= bus.din[0];
        end
        if (epc_wr)
          epc_q <= din_word;
      end
    end
  end

  always_comb begin
    bus.dout = 32'd0;
    case (bus.addr)
      5'd12:   bus.dout = {16'd0, im_q, 8'd0, exl, ie_q};
      5'd13:   bus.dout = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
      5'd14:   bus.dout = epc_q;
      5'd15:   bus.dout = PRID;
      default: bus.dout = 32'd0;
    endcase
  end

  assign bus.req        = req;
  assign bus.handler_pc = HANDLER_PC;
  // Bypass lets an mtc0 EPC followed by eret in the same slot return correctly.
  assign bus.epc_out    = (bus.we && bus.addr == 5'd14) ? din_word : epc_q;
  assign state_dbg      = exl;

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID       = 32'h2020_0707;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset;
  logic state_dbg;
  int   vectors = 0;
  int   miscompares = 0;

  cp0_exc_if bus ();

  cp0_exc_unit #(.PRID(PRID), .HANDLER_PC(HANDLER_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid = 1'b0; bus.pc = 32'd0; bus.bd = 1'b0; bus.exccode = 5'd0;
    bus.hwint = 6'd0; bus.we = 1'b0; bus.addr = 5'd0; bus.din = 32'd0;
    bus.eret = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.dout, exp);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;

    // reset state
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, PRID);
    chk("rst_epc_out", bus.epc_out, 32'h0);
    chk("handler_pc", bus.handler_pc, HANDLER_PC);
    bus.hwint = 6'h3F; bus.valid = 1'b1; #1;
    chk("rst_req_ie0", {31'd0, bus.req}, 32'd0);

    // mtc0 SR = IM[10] | IE
    idle_inputs();
    bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_0401;
    tick();
    idle_inputs();
    rd("sr_after_mtc0", 5'd12, 32'h0000_0401);

    // interrupt taken
    bus.hwint = 6'b000001; bus.valid = 1'b1; bus.pc = 32'h3010; #1;
    chk("int_req", {31'd0, bus.req}, 32'd1);
    tick();
    bus.valid = 1'b0;
    rd("int_epc", 5'd14, 32'h3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    chk("int_state", {31'd0, state_dbg}, 32'd1);
    bus.valid = 1'b1; #1;
    chk("int_req_masked", {31'd0, bus.req}, 32'd0);

    // in HANDLER: nested exception masked
    bus.hwint = 6'd0; bus.exccode = 5'd10; bus.pc = 32'h3014; #1;
    chk("nest_req", {31'd0, bus.req}, 32'd0);
    tick();
    bus.exccode = 5'd0;
    rd("nest_epc", 5'd14, 32'h3010);
    rd("nest_cause", 5'd13, 32'h0);
    rd("nest_sr", 5'd12, 32'h0000_0403);

    // eret leaves handler, epc_out unchanged
    bus.eret = 1'b1; #1;
    chk("eret_epc_out", bus.epc_out, 32'h3010);
    tick();
    bus.eret = 1'b0; bus.valid = 1'b0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    chk("eret_state", {31'd0, state_dbg}, 32'd0);

    // synchronous exception in delay slot
    bus.valid = 1'b1; bus.exccode = 5'd4; bus.bd = 1'b1; bus.pc = 32'h3024; #1;
    chk("exc_req", {31'd0, bus.req}, 32'd1);
    tick();
    idle_inputs();
    rd("exc_epc", 5'd14, 32'h3020);
    rd("exc_cause", 5'd13, 32'h8000_0010);
    bus.valid = 1'b1; bus.eret = 1'b1;
    tick();
    idle_inputs();

    // bubble rule
    bus.hwint = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bubble_req", {31'd0, bus.req}, 32'd0);
      tick();
    end
    bus.valid = 1'b1; bus.pc = 32'h3040; #1;
    chk("bubble_take", {31'd0, bus.req}, 32'd1);
    tick();
    bus.valid = 1'b0;
    rd("bubble_epc", 5'd14, 32'h3040);
    rd("bubble_cause", 5'd13, 32'h0000_0400);
    bus.hwint = 6'd0; bus.valid = 1'b1; bus.eret = 1'b1;
    tick();
    idle_inputs();

    // simultaneous req and eret: req wins
    bus.valid = 1'b1; bus.exccode = 5'd12; bus.pc = 32'h3100; bus.eret = 1'b1; #1;
    chk("req_eret_req", {31'd0, bus.req}, 32'd1);
    tick();
    idle_inputs();
    rd("req_eret_sr", 5'd12, 32'h0000_0403);
    rd("req_eret_epc", 5'd14, 32'h3100);
    rd("req_eret_cause", 5'd13, 32'h0000_0030);
    bus.valid = 1'b1; bus.eret = 1'b1;
    tick();
    idle_inputs();

    // EPC wrap: pc=0 in delay slot
    bus.valid = 1'b1; bus.exccode = 5'd1; bus.bd = 1'b1; bus.pc = 32'h0; #1;
    chk("wrap_req", {31'd0, bus.req}, 32'd1);
    tick();
    idle_inputs();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0004);

    // mtc0 SR clearing EXL leaves handler
    bus.we = 1'b1; bus.addr = 5'd12; bus.din = 32'h0000_0401;
    tick();
    idle_inputs();
    chk("mtc0_exit_state", {31'd0, state_dbg}, 32'd0);

    // mtc0 EPC with eret in same cycle: bypass
    bus.valid = 1'b1; bus.we = 1'b1; bus.addr = 5'd14; bus.din = 32'h0000_5007;
    bus.eret = 1'b1; #1;
    chk("bypass_epc_out", bus.epc_out, 32'h0000_5004);
    tick();
    idle_inputs();
    rd("bypass_epc", 5'd14, 32'h0000_5004);
    chk("bypass_epc_out_after", bus.epc_out, 32'h0000_5004);

    // Cause and unmapped registers ignore writes
    bus.we = 1'b1; bus.addr = 5'd13; bus.din = 32'hFFFF_FFFF;
    tick();
    bus.addr = 5'd5;
    tick();
    bus.we = 1'b0;
    rd("cause_ro", 5'd13, 32'h8000_0004);
    rd("unmapped_rd", 5'd5, 32'h0);

    // reset mid-handler
    bus.valid = 1'b1; bus.exccode = 5'd4; bus.pc = 32'h3200;
    tick();
    idle_inputs();
    chk("pre_rst_state", {31'd0, state_dbg}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("midrst_sr", 5'd12, 32'h0);
    rd("midrst_epc", 5'd14, 32'h0);
    rd("midrst_cause", 5'd13, 32'h0);
    chk("midrst_state", {31'd0, state_dbg}, 32'd0);

    // scoreboard report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
# cp0_exc_unit

Coprocessor-0 and exception controller at the MEM end of the pipeline. It consumes the exception code, PC, delay-slot flag and CP0-access fields that the EX/MEM stage register delivers. It decides whether to take an interrupt or exception, and records Cause, EPC and status state. It drives back the redirect and pipeline-clear request that empties the upstream stage registers.

## Interface
Parameters:
- PRID, 32'h2020_0707, read-only processor ID returned for register 15
- HANDLER_PC, 32'h0000_4180, exception entry address

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous, active-high
- valid  input  1  MEM slot holds a real instruction (0 = bubble from a cleared stage)
- pc  input  32  PC of the MEM-stage instruction
- bd  input  1  MEM instruction sits in a branch delay slot
- exccode  input  5  exception code carried from earlier stages; 0 = none
- hwint  input  6  external interrupt lines, level-sensitive
- we  input  1  mtc0 write strobe
- addr  input  5  CP0 register number for mtc0/mfc0
- din  input  32  mtc0 write data
- eret  input  1  MEM instruction is eret
- dout  output  32  mfc0 read data, combinational on addr
- req  output  1  take exception/interrupt this cycle: flush pipeline, redirect fetch to HANDLER_PC
- handler_pc  output  32  constant HANDLER_PC
- epc_out  output  32  eret return address

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0. Software cannot write Cause.
  - EPC (14): bits[1:0] always 0.
  - PRId (15): PRID.
  - Any other addr reads 0 and ignores writes.
- int_req = valid & IE & !EXL & |(hwint & IM).
- exc_req = valid & !EXL & (exccode != 0).
- req = int_req | exc_req; combinational from current state and inputs.
- Priority: interrupt over synchronous exception. Exception or interrupt over mtc0 and eret in the same cycle; the faulting instruction does not commit.
- On req at edge:
  - EXL<=1.
  - BD<=bd.
  - ExcCode<=int_req ? 0 : exccode.
  - EPC<={(bd ? pc-4 : pc)[31:2],2'b00}.
- IP<=hwint every cycle, independent of req and EXL.
- eret (no req) at edge: EXL<=0. No other field changes.
- mtc0 (we, no req) at edge:
  - addr 12: IM, EXL and IE load from din.
  - addr 14: EPC loads {din[31:2],2'b00}.
- Two-state view: NORMAL (EXL=0) -> HANDLER on req; HANDLER -> NORMAL on eret or mtc0 clearing EXL. In HANDLER, req is forced 0 (nested exceptions masked).
- Bubble rule: valid=0 suppresses req even with pending hwint. The interrupt is taken at the first valid slot, so EPC never records a bubble PC.
- epc_out bypass: if we & addr==14 this cycle, epc_out={din[31:2],2'b00}; else EPC.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, dout=0 for addr≠15, req=0, epc_out=0. handler_pc=HANDLER_PC always.
- req and dout are same-cycle combinational. State effects are visible the cycle after the edge.
- Flush contract: the req cycle is the last cycle the faulting instruction occupies MEM. The next cycle fetch is at HANDLER_PC and all upstream stage registers hold cleared values.
- IP lags hwint by one cycle in Cause reads. int_req uses live hwint, not IP.
- Reset mid-handler clears EXL; the pending exception is lost.
- Simultaneous req and eret: req wins and EXL stays 1. EPC is overwritten with the eret PC (bd rule applied).
- EPC arithmetic is modulo 2^32; pc=0 with bd=1 yields EPC=32'hFFFF_FFFC.

## Test plan
- Reset, then read addr 12/13/14/15 -> 0, 0, 0, PRID; req=0 with hwint=6'h3F.
- mtc0 SR=32'h0000_0401 (IM[10], IE); hwint=6'b000001, valid=1, pc=32'h3010 -> req=1 that cycle. Next cycle: EPC=32'h3010, ExcCode=0, EXL=1, IP[10]=1, req=0.
- exccode=5'd4, bd=1, pc=32'h3024, EXL=0 -> req=1. Next cycle: EPC=32'h3020, Cause=32'h8000_0010.
- Bubble rule: hwint enabled while valid=0 for 3 cycles -> req=0 throughout. Then valid=1, pc=32'h3040 -> req=1 and EPC=32'h3040.
- In HANDLER: exccode=5'd10 with valid -> req=0 and state unchanged. eret -> EXL=0 next cycle, epc_out unchanged.
- mtc0 EPC din=32'h0000_5007 with eret same cycle -> epc_out=32'h5004 that cycle; EPC=32'h5004 after the edge.
